// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and the transmit arbiter state encoding
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int SYSTEM_CLOCK = 50_000_000;
    localparam int BAUD_RATE    = 115_200;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searching upward from last_grant+1
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter sharing one uart_tx between N_REQ byte streams
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*UART_DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_en,
    output logic [UART_DATA_W-1:0]       tx_data,
    input  logic                         tx_rdy,
    output logic [N_REQ-1:0]             grant,
    output logic                         busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int TO_W   = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t             state, state_next;
    logic [IDX_W-1:0]       own, last_grant, pick_idx;
    logic                   pick_found;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic [UART_DATA_W-1:0] lanes [N_REQ];
    logic [N_REQ-1:0]       own_onehot;
    logic                   locked, own_valid, xfer, beat_hit, to_hit, rel;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lanes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    assign locked     = (state == ST_LOCKED);
    assign own_valid  = req_valid[own];
    assign own_onehot = N_REQ'(1) << own;
    assign xfer       = locked & tx_rdy & own_valid;
    assign beat_hit   = (beat_cnt == BEAT_W'(MAX_BURST - 1));
    assign to_hit     = (to_cnt == TO_W'(IDLE_TIMEOUT - 1));

    assign tx_en     = xfer;
    assign tx_data   = locked ? lanes[own] : '0;
    assign grant     = locked ? own_onehot : '0;
    assign req_ready = (locked & tx_rdy) ? own_onehot : '0;
    assign busy      = locked;

    // Timeout can only fire on a cycle with no owner data, so it never races a transfer.
    always_comb begin
        state_next = state;
        rel        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (xfer)            rel = req_last[own] | beat_hit;
                else if (!own_valid) rel = to_hit;
                if (rel) state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own        <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            beat_cnt   <= '0;
            to_cnt     <= '0;
        end else if (!locked) begin
            if (pick_found) begin
                own      <= pick_idx;
                beat_cnt <= '0;
                to_cnt   <= '0;
            end
        end else begin
            if (xfer) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
                to_cnt   <= '0;
            end else if (!own_valid) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (rel) last_grant <= own;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 16;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0, req_last = '0, req_ready, grant;
    logic [N*8-1:0] req_data = '0;
    logic           tx_en, busy;
    logic           tx_rdy = 1'b0;
    logic [7:0]     tx_data;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_rdy    (tx_rdy),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Requester byte sources: {last, data}, gated by en_mask to emulate a dropped req_valid.
    logic [8:0] q [N][$];
    logic [N-1:0] en_mask;
    int m_owner, m_last, m_beats, m_wait;
    logic e_busy, e_tx_en;
    logic [N-1:0] e_grant, e_ready;
    logic [7:0] e_data;
    int d_log[$];
    int checks = 0;
    int errors = 0;

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_beats = 0; m_wait = 0;
        for (int i = 0; i < N; i++) q[i].delete();
        en_mask = '1; d_log.delete(); tx_rdy = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_and_expect();
        for (int i = 0; i < N; i++) begin
            if (en_mask[i] && q[i].size() != 0) begin
                req_valid[i] = 1'b1;
                req_last[i]  = q[i][0][8];
                req_data[i*8 +: 8] = q[i][0][7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'($urandom);
                req_data[i*8 +: 8] = 8'($urandom);
            end
        end
        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? (N'(1) << m_owner) : '0;
        e_tx_en = e_busy && tx_rdy && req_valid[m_owner];
        e_data  = e_busy ? req_data[m_owner*8 +: 8] : 8'h00;
        e_ready = (e_busy && tx_rdy) ? e_grant : '0;
        #1;
    endtask

    task automatic log_dut();
        if (tx_en === 1'b1) d_log.push_back(onehot_idx(grant) * 256 + int'(tx_data));
    endtask

    task automatic model_update();
        bool_found: begin end
        if (m_owner < 0) begin
            int pick = -1;
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (pick < 0 && req_valid[c]) pick = c;
            end
            if (pick >= 0) begin m_owner = pick; m_beats = 0; m_wait = 0; end
        end else if (e_tx_en) begin
            void'(q[m_owner].pop_front());
            m_beats++; m_wait = 0;
            if (req_last[m_owner] || m_beats == MB) begin m_last = m_owner; m_owner = -1; end
        end else if (!req_valid[m_owner]) begin
            m_wait++;
            if (m_wait == TO) begin m_last = m_owner; m_owner = -1; end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 checks++;
        if ({busy, grant, tx_en, req_ready, tx_data} !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h required=0", {busy, grant, tx_en, req_ready, tx_data});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); tx_rdy = 1'($urandom); drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== '0) begin
                errors++; $display("FAIL reset_idle cyc=%0d got=%h required=0", c, {busy, grant, tx_en, req_ready, tx_data});
            end
            model_update();
        end
    endtask

    task automatic test_two_msgs();
        logic [7:0] b1 [3], b3 [3];
        int gtr[$], exp_log[$], last1, first3;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            b1[i] = 8'($urandom); b3[i] = 8'($urandom);
            q[1].push_back({i == 2, b1[i]}); q[3].push_back({i == 2, b3[i]});
            exp_log.push_back(256 + int'(b1[i]));
        end
        for (int i = 0; i < 3; i++) exp_log.push_back(3 * 256 + int'(b3[i]));
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); tx_rdy = 1'($urandom); drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== {e_busy, e_grant, e_tx_en, e_ready, e_data}) begin
                errors++; $display("FAIL two_msgs cyc=%0d got=%h required=%h", c, {busy, grant, tx_en, req_ready, tx_data}, {e_busy, e_grant, e_tx_en, e_ready, e_data});
            end
            gtr.push_back(int'(grant)); log_dut(); model_update();
        end
        checks++;
        if (d_log != exp_log) begin
            errors++; $display("FAIL two_msgs_order got %0d bytes required 6 in order 1 then 3", d_log.size());
        end
        last1 = -100; first3 = 1000;
        foreach (gtr[i]) begin
            if (gtr[i] == 2) last1 = i;
            if (gtr[i] == 8 && first3 == 1000) first3 = i;
        end
        checks++;
        if (first3 - last1 - 1 != 1) begin
            errors++; $display("FAIL two_msgs_gap got=%0d required=1", first3 - last1 - 1);
        end
    endtask

    task automatic test_max_burst();
        int exp_own;
        do_reset();
        for (int i = 0; i < 40; i++) q[0].push_back({1'b0, 8'($urandom)});
        for (int i = 0; i < 20; i++) q[2].push_back({1'b0, 8'($urandom)});
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); tx_rdy = ($urandom_range(0, 3) != 0); drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== {e_busy, e_grant, e_tx_en, e_ready, e_data}) begin
                errors++; $display("FAIL max_burst cyc=%0d got=%h required=%h", c, {busy, grant, tx_en, req_ready, tx_data}, {e_busy, e_grant, e_tx_en, e_ready, e_data});
            end
            log_dut(); model_update();
        end
        checks++;
        if (d_log.size() != 60) begin
            errors++; $display("FAIL max_burst_count got=%0d required=60", d_log.size());
        end
        for (int k = 0; k < 60 && k < d_log.size(); k++) begin
            exp_own = (k < 48) ? (((k / 16) % 2 == 0) ? 0 : 2) : ((k < 52) ? 2 : 0);
            checks++;
            if (d_log[k] / 256 != exp_own) begin
                errors++; $display("FAIL max_burst_owner beat=%0d got=%0d required=%0d", k, d_log[k] / 256, exp_own);
            end
        end
    endtask

    task automatic test_timeout();
        int xfer_cyc = -1, fall_cyc = -1;
        logic [N-1:0] next_g = '0;
        do_reset();
        q[2].push_back({1'b0, 8'($urandom)}); q[2].push_back({1'b1, 8'($urandom)});
        q[3].push_back({1'b0, 8'($urandom)}); q[3].push_back({1'b1, 8'($urandom)});
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); tx_rdy = 1'b1; drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== {e_busy, e_grant, e_tx_en, e_ready, e_data}) begin
                errors++; $display("FAIL timeout cyc=%0d got=%h required=%h", c, {busy, grant, tx_en, req_ready, tx_data}, {e_busy, e_grant, e_tx_en, e_ready, e_data});
            end
            if (xfer_cyc < 0 && tx_en === 1'b1 && grant === 4'b0100) begin xfer_cyc = c; en_mask[2] = 1'b0; end
            else if (xfer_cyc >= 0 && fall_cyc < 0 && busy === 1'b0) fall_cyc = c;
            else if (fall_cyc >= 0 && next_g == '0 && grant !== '0) next_g = grant;
            log_dut(); model_update();
        end
        checks++;
        if (xfer_cyc < 0 || fall_cyc - xfer_cyc - 1 != TO) begin
            errors++; $display("FAIL timeout_len got=%0d required=%0d", fall_cyc - xfer_cyc - 1, TO);
        end
        checks++;
        if (next_g !== 4'b1000) begin
            errors++; $display("FAIL timeout_next got=%b required=1000", next_g);
        end
    endtask

    task automatic test_last_at_beat16();
        int gtr[$], last1, first2;
        do_reset();
        for (int i = 0; i < 16; i++) q[1].push_back({i == 15, 8'($urandom)});
        for (int i = 0; i < 4; i++) q[1].push_back({i == 3, 8'($urandom)});
        for (int i = 0; i < 3; i++) q[2].push_back({i == 2, 8'($urandom)});
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); tx_rdy = 1'b1; drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== {e_busy, e_grant, e_tx_en, e_ready, e_data}) begin
                errors++; $display("FAIL last16 cyc=%0d got=%h required=%h", c, {busy, grant, tx_en, req_ready, tx_data}, {e_busy, e_grant, e_tx_en, e_ready, e_data});
            end
            gtr.push_back(int'(grant)); log_dut(); model_update();
        end
        checks++;
        if (d_log.size() < 17 || d_log[15] / 256 != 1 || d_log[16] / 256 != 2) begin
            errors++; $display("FAIL last16_next got_bytes=%0d required beat17 from requester 2", d_log.size());
        end
        last1 = -100; first2 = 1000;
        foreach (gtr[i]) begin
            if (gtr[i] == 2 && first2 == 1000) last1 = i;
            if (gtr[i] == 4 && first2 == 1000) first2 = i;
        end
        checks++;
        if (first2 - last1 - 1 != 1) begin
            errors++; $display("FAIL last16_gap got=%0d required=1", first2 - last1 - 1);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [N-1:0] first_g = '0;
        do_reset();
        for (int i = 0; i < 10; i++) q[1].push_back({1'b0, 8'($urandom)});
        for (int c = 0; c < 30 && d_log.size() < 4; c++) begin
            @(negedge clk); tx_rdy = 1'b1; drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== {e_busy, e_grant, e_tx_en, e_ready, e_data}) begin
                errors++; $display("FAIL mid_rst cyc=%0d got=%h required=%h", c, {busy, grant, tx_en, req_ready, tx_data}, {e_busy, e_grant, e_tx_en, e_ready, e_data});
            end
            log_dut(); model_update();
        end
        checks++;
        if (d_log.size() != 4) begin
            errors++; $display("FAIL mid_rst_reach got=%0d required=4", d_log.size());
        end
        @(negedge clk); tx_rdy = 1'b1; drive_and_expect();
        rst = 1'b1;
        #1 checks++;
        if ({busy, grant, tx_en, req_ready, tx_data} !== '0) begin
            errors++; $display("FAIL mid_rst_async got=%h required=0", {busy, grant, tx_en, req_ready, tx_data});
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            q[0].push_back({i == 2, 8'($urandom)}); q[1].push_back({i == 2, 8'($urandom)});
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); tx_rdy = 1'b1; drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== {e_busy, e_grant, e_tx_en, e_ready, e_data}) begin
                errors++; $display("FAIL mid_rst_after cyc=%0d got=%h required=%h", c, {busy, grant, tx_en, req_ready, tx_data}, {e_busy, e_grant, e_tx_en, e_ready, e_data});
            end
            if (first_g == '0 && grant !== '0) first_g = grant;
            log_dut(); model_update();
        end
        checks++;
        if (first_g !== 4'b0001) begin
            errors++; $display("FAIL mid_rst_first got=%b required=0001", first_g);
        end
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < int'($urandom_range(1, 3)); m++) begin
                len = $urandom_range(1, 20);
                for (int b = 0; b < len; b++) q[i].push_back({b == len - 1, 8'($urandom)});
            end
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            tx_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) en_mask[$urandom_range(0, N - 1)] ^= 1'b1;
            if (c > 1300) en_mask = '1;
            drive_and_expect();
            checks++;
            if ({busy, grant, tx_en, req_ready, tx_data} !== {e_busy, e_grant, e_tx_en, e_ready, e_data}) begin
                errors++; $display("FAIL random cyc=%0d got=%h required=%h", c, {busy, grant, tx_en, req_ready, tx_data}, {e_busy, e_grant, e_tx_en, e_ready, e_data});
            end
            log_dut(); model_update();
        end
    endtask

    initial begin
        test_reset();
        test_two_msgs();
        test_max_burst();
        test_timeout();
        test_last_at_beat16();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
